sha256_wt_datapath: RTL and testbench

Sequential SHA-256 message-schedule arithmetic unit. It computes one expanded word W[t] = σ1(W[t-2]) + W[t-7] + σ0(W[t-15]) + W[t-16] (mod 2^32) using a single shared 32-bit adder over three add cycles. The unit sits between the 16-word schedule memory, which supplies the four operands, and the compression round, which consumes `w_out`. It contains the small-sigma functions and the adder; the schedule memory and address generation are outside this block.

---
 rtl/sha256_pkg.sv | 11 +
 rtl/sha256_small_sigma.sv | 15 +
 rtl/sha256_wt_datapath.sv | 53 +++++
 tb/tb_sha256_wt_datapath.sv | 115 +++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// sha256_pkg: shared word width, small-sigma constants and schedule FSM states
package sha256_pkg;
  localparam int WIDTH = 32;
  localparam int S0_ROT_A = 7;
  localparam int S0_ROT_B = 18;
  localparam int S0_SHR = 3;
  localparam int S1_ROT_A = 17;
  localparam int S1_ROT_B = 19;
  localparam int S1_SHR = 10;
  typedef enum logic [1:0] {IDLE, ADD0, ADD1, ADD2} state_t;
endpackage

// File: rtl/sha256_small_sigma.sv
// sha256_small_sigma: ROTR(a) ^ ROTR(b) ^ SHR(s) on one word
module sha256_small_sigma
  import sha256_pkg::*;
#(
  parameter int ROT_A = 7,
  parameter int ROT_B = 18,
  parameter int SHR = 3
) (
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y
);
  assign y = ((x >> ROT_A) | (x << (WIDTH - ROT_A))) ^
             ((x >> ROT_B) | (x << (WIDTH - ROT_B))) ^
             (x >> SHR);
endmodule

// File: rtl/sha256_wt_datapath.sv
// sha256_wt_datapath: W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16] over three adds on one adder
module sha256_wt_datapath
  import sha256_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] w_t16,
  input  logic [WIDTH-1:0] w_t15,
  input  logic [WIDTH-1:0] w_t7,
  input  logic [WIDTH-1:0] w_t2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] w_out
);
  state_t state, state_nx;
  logic [WIDTH-1:0] op16, op15, op7, op2, acc, s0, s1, add_a, add_b, sum;
  sha256_small_sigma #(.ROT_A(S0_ROT_A), .ROT_B(S0_ROT_B), .SHR(S0_SHR)) u_s0 (.x(op15), .y(s0));
  sha256_small_sigma #(.ROT_A(S1_ROT_A), .ROT_B(S1_ROT_B), .SHR(S1_SHR)) u_s1 (.x(op2), .y(s1));
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_nx;
  always_comb begin
    state_nx = state == IDLE ? (start ? ADD0 : IDLE) :
               state == ADD0 ? ADD1 :
               state == ADD1 ? ADD2 : IDLE;
  end
  // One shared adder; both inputs held at zero while idle
  assign add_a = state == ADD0 ? op16 : state == IDLE ? '0 : acc;
  assign add_b = state == ADD0 ? s0 : state == ADD1 ? op7 : state == ADD2 ? s1 : '0;
  assign sum = add_a + add_b;
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (reset) begin
      op16 <= '0;
      op15 <= '0;
      op7 <= '0;
      op2 <= '0;
      acc <= '0;
      w_out <= '0;
      done <= 1'b0;
    end else begin
      done <= state == ADD2;
      if (state == IDLE && start) begin
        op16 <= w_t16;
        op15 <= w_t15;
        op7 <= w_t7;
        op2 <= w_t2;
      end
      if (state == ADD0 || state == ADD1) acc <= sum;
      if (state == ADD2) w_out <= sum;
    end
  end
endmodule

// File: tb/tb_sha256_wt_datapath.sv
// tb_sha256_wt_datapath: directed vectors with a queue scoreboard checked on each done pulse
module tb_sha256_wt_datapath;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [31:0] w_t16 = '0, w_t15 = '0, w_t7 = '0, w_t2 = '0;
  logic busy, done;
  logic [31:0] w_out;
  logic [31:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  bit running = 1'b1;

  sha256_wt_datapath dut (
    .clk(clk), .reset(reset), .start(start),
    .w_t16(w_t16), .w_t15(w_t15), .w_t7(w_t7), .w_t2(w_t2),
    .busy(busy), .done(done), .w_out(w_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  initial begin
    while (running) begin
      @(negedge clk);
      if (done) begin
        if (exp_q.size() == 0) check("unexpected_done", 32'(done), 32'd0);
        else check("w_out", w_out, exp_q.pop_front());
      end
    end
  end

  task automatic drive(input logic [31:0] a16, a15, a7, a2);
    w_t16 = a16;
    w_t15 = a15;
    w_t7 = a7;
    w_t2 = a2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_vec(input logic [31:0] a16, a15, a7, a2, exp);
    exp_q.push_back(exp);
    drive(a16, a15, a7, a2);
    for (int i = 0; i < 3; i++) begin
      check("busy_inflight", 32'(busy), 32'd1);
      check("done_early", 32'(done), 32'd0);
      @(negedge clk);
    end
    check("done_latency", 32'(done), 32'd1);
    check("busy_after", 32'(busy), 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_w_out", w_out, 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_done", 32'(done), 32'd0);
    end
    run_vec(32'h61626380, 32'h0, 32'h0, 32'h0, 32'h61626380);
    run_vec(32'h0, 32'h0, 32'h0, 32'h00000018, 32'h000F0000);
    run_vec(32'h0, 32'h1, 32'h0, 32'h1, 32'h0200E000);
    run_vec(32'hFFFFFFFF, 32'h0, 32'h1, 32'h0, 32'h00000000);
    run_vec(32'h1, 32'h80000000, 32'h10, 32'h80000000, 32'h11207011);
    // Back-to-back: next start issued in the done cycle
    run_vec(32'h0, 32'h0, 32'h0, 32'h00000018, 32'h000F0000);
    // Ports change and start pulses while busy; captured operands must win
    exp_q.push_back(32'h0200E000);
    drive(32'h0, 32'h1, 32'h0, 32'h1);
    w_t16 = 32'hDEADBEEF;
    w_t15 = 32'h12345678;
    w_t7 = 32'hCAFEF00D;
    w_t2 = 32'h0BADF00D;
    start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("busy_start_done", 32'(done), 32'd1);
    repeat (6) @(negedge clk);
    check("busy_start_queue", 32'(exp_q.size()), 32'd0);
    // Reset while in ADD1 aborts the word
    drive(32'h5, 32'h0, 32'h7, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    check("abort_w_out", w_out, 32'h0);
    check("abort_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 5; i++) begin
      check("abort_done", 32'(done), 32'd0);
      @(negedge clk);
    end
    run_vec(32'h61626380, 32'h0, 32'h0, 32'h0, 32'h61626380);
    repeat (4) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    running = 1'b0;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
